keypad_input_buffer: RTL and testbench

//   Downstream stage of keypad_peripheral. Acknowledges each key the scanner reports and

---
 rtl/keypad_input_buffer.sv | 157 +++++++++++++++
 tb/tb_keypad_input_buffer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_input_buffer.sv
// Keypad input buffer: acknowledges scanner codes, filters auto-repeat,
// queues accepted codes in a FIFO and exposes DATA/STATUS registers to the CPU.
module keypad_input_buffer #(
  parameter int DEPTH       = 8,
  parameter int AW          = 3,
  parameter int HOLD_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  key_in,
  input  logic        key_ready,
  output logic        key_read,
  input  logic        cpu_rd,
  input  logic        cpu_addr,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam int QW = $clog2(HOLD_CYCLES + 1);
  localparam logic [QW-1:0] HOLD = QW'(HOLD_CYCLES);
  localparam logic [AW:0] FULLC = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACK,
    S_WAIT
  } state_e;

  state_e          state_q;
  logic [7:0]      cap_q;
  logic [7:0]      last_q;
  logic [QW-1:0]   quiet_q;
  logic            key_read_q;

  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            irq_q, irq_d;

  logic            accept;
  logic            push;
  logic            empty;
  logic            full;
  logic            data_rd;
  logic            stat_rd;
  logic            pop;
  logic            wr_en;
  logic            ovf_set;

  // Capture FSM; quiet_q counts idle time since the last capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cap_q      <= 8'h00;
      last_q     <= 8'h00;
      quiet_q    <= HOLD;
      key_read_q <= 1'b0;
    end else begin
      key_read_q <= 1'b0;
      if (state_q != S_ACK && quiet_q != HOLD) begin
        quiet_q <= quiet_q + 1'b1;
      end
      unique case (state_q)
        S_IDLE: begin
          if (key_ready) begin
            cap_q      <= key_in;
            key_read_q <= 1'b1;
            state_q    <= S_ACK;
          end
        end
        S_ACK: begin
          last_q  <= cap_q;
          quiet_q <= '0;
          state_q <= key_ready ? S_WAIT : S_IDLE;
        end
        S_WAIT: begin
          if (!key_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign accept = !((cap_q == last_q) && (quiet_q < HOLD));
  assign push   = (state_q == S_ACK) && accept;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULLC);
  assign data_rd = cpu_rd && !cpu_addr;
  assign stat_rd = cpu_rd && cpu_addr;
  assign pop     = data_rd && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign wr_en   = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    ovf_d = ovf_set | (ovf_q & !stat_rd);
    irq_d = (count_d != '0);
    rdata_d = rdata_q;
    if (data_rd) begin
      rdata_d = empty ? 32'h0 : {24'h0, mem_q[rd_ptr_q]};
    end else if (stat_rd) begin
      rdata_d = {16'h0, 8'(count_q), 5'b0, ovf_q, full, !empty};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      rdata_q  <= 32'h0;
      irq_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem_q[wr_ptr_q] <= cap_q;
    end
  end

  assign key_read = key_read_q;
  assign rdata    = rdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_keypad_input_buffer.sv
// Directed bench for keypad_input_buffer: capture handshake, repeat filter,
// FIFO ordering, overflow, simultaneous push/pop and reset mid-capture.
module tb_keypad_input_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  key_in;
  logic        key_ready;
  logic        key_read;
  logic        cpu_rd;
  logic        cpu_addr;
  logic [31:0] rdata;
  logic        irq;

  int checks = 0;
  int failures = 0;

  keypad_input_buffer #(
    .DEPTH(8),
    .AW(3),
    .HOLD_CYCLES(1024)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_in(key_in),
    .key_ready(key_ready),
    .key_read(key_read),
    .cpu_rd(cpu_rd),
    .cpu_addr(cpu_addr),
    .rdata(rdata),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One scanner report; optionally a DATA read lands on the ACK edge.
  task automatic press(logic [7:0] k, bit rd_in_ack = 1'b0);
    key_in = k;
    key_ready = 1'b1;
    tick();
    chk1("key_read_pulse", key_read, 1'b1);
    key_ready = 1'b0;
    if (rd_in_ack) begin
      cpu_rd = 1'b1;
      cpu_addr = 1'b0;
    end
    tick();
    cpu_rd = 1'b0;
    chk1("key_read_end", key_read, 1'b0);
    tick();
  endtask

  task automatic rdchk(string tag, bit a, logic [31:0] exp);
    cpu_rd = 1'b1;
    cpu_addr = a;
    tick();
    cpu_rd = 1'b0;
    chk(tag, rdata, exp);
  endtask

  initial begin
    rst = 1'b1;
    key_in = 8'h00;
    key_ready = 1'b0;
    cpu_rd = 1'b0;
    cpu_addr = 1'b0;
    tick(3);
    chk1("rst_key_read", key_read, 1'b0);
    chk1("rst_irq", irq, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    rst = 1'b0;
    tick();

    // single key, then DATA and STATUS
    press(8'h35);
    chk1("irq_after_push", irq, 1'b1);
    rdchk("data_5", 1'b0, 32'h35);
    rdchk("status_after_5", 1'b1, 32'h0);
    chk1("irq_after_pop", irq, 1'b0);

    // held '7' re-reported within the hold window
    press(8'h37);
    tick(100);
    press(8'h37);
    tick(100);
    press(8'h37);
    rdchk("status_repeat", 1'b1, 32'h0000_0101);
    rdchk("data_repeat", 1'b0, 32'h37);

    // same key after a long quiet gap is accepted
    tick(1100);
    press(8'h37);
    tick(1100);
    press(8'h37);
    rdchk("status_gap", 1'b1, 32'h0000_0201);
    rdchk("data_gap0", 1'b0, 32'h37);
    rdchk("data_gap1", 1'b0, 32'h37);

    // two different keys back to back
    tick(1100);
    press(8'h37);
    press(8'h38);
    rdchk("data_order0", 1'b0, 32'h37);
    rdchk("data_order1", 1'b0, 32'h38);

    // 9 distinct keys into an 8-deep FIFO
    for (int i = 0; i < 9; i++) begin
      press(8'h41 + 8'(i));
    end
    rdchk("status_ovf", 1'b1, 32'h0000_0807);
    rdchk("status_ovf_clr", 1'b1, 32'h0000_0803);

    // push and pop in the same cycle while full
    press(8'h4A, 1'b1);
    chk("data_full_pushpop", rdata, 32'h41);
    rdchk("status_full_pushpop", 1'b1, 32'h0000_0803);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] e;
      e = (i < 7) ? 32'h42 + 32'(i) : 32'h4A;
      rdchk("data_drain", 1'b0, e);
    end
    rdchk("status_drained", 1'b1, 32'h0);
    chk1("irq_drained", irq, 1'b0);

    // empty-FIFO DATA read
    rdchk("data_empty", 1'b0, 32'h0);
    rdchk("status_empty", 1'b1, 32'h0);
    chk1("irq_empty", irq, 1'b0);

    // push and pop in the same cycle while empty
    press(8'h4B, 1'b1);
    chk("data_empty_pushpop", rdata, 32'h0);
    rdchk("status_empty_pushpop", 1'b1, 32'h0000_0101);
    rdchk("data_after_pushpop", 1'b0, 32'h4B);

    // reset while the scanner still holds a key
    press(8'h61);
    press(8'h62);
    key_in = 8'h63;
    key_ready = 1'b1;
    tick();
    chk1("wd_key_read", key_read, 1'b1);
    tick();
    chk1("wd_key_read_lo", key_read, 1'b0);
    rdchk("status_wd", 1'b1, 32'h0000_0301);
    rst = 1'b1;
    key_ready = 1'b0;
    tick();
    chk1("rst_mid_key_read", key_read, 1'b0);
    chk1("rst_mid_irq", irq, 1'b0);
    rst = 1'b0;
    rdchk("status_after_rst", 1'b1, 32'h0);
    chk1("irq_after_rst", irq, 1'b0);
    press(8'h65);
    rdchk("data_after_rst", 1'b0, 32'h65);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
